// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - 2-stage FP32 / FP16x2 round-to-nearest-even and pack (optional flags: FPALL_ROUND_FLAGS_EN)
package FPALL_pkg;
    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1
    } fp_fmt_e;
endpackage

module fp_round_pack
    import FPALL_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  fp_fmt_e     fmt,
    input  logic [27:0] frac_i,
    input  logic [4:0]  cnt_h,
    input  logic [4:0]  cnt_l,
    input  logic [5:0]  exp_h,
    input  logic [8:0]  exp_l,
    input  logic        sign_h,
    input  logic        sign_l,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef FPALL_ROUND_FLAGS_EN
    ,
    output logic [2:0]  flags_h,
    output logic [2:0]  flags_l
`endif
);

    // Handshake
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_free;
    logic        in_fire;

    // Stage-1 decode (combinational from inputs)
    logic        is_fp32;
    logic [9:0]  adj_32;
    logic [6:0]  adj_h16;
    logic [6:0]  adj_l16;
    logic [22:0] nx_mant_l;
    logic [9:0]  nx_exp_l;
    logic        nx_hid_l;
    logic        nx_lsb_l;
    logic        nx_grd_l;
    logic        nx_stk_l;
    logic        nx_inc_l;
    logic        nx_uf_l;
    logic [9:0]  nx_mant_h;
    logic        nx_hid_h;
    logic        nx_grd_h;
    logic        nx_stk_h;
    logic        nx_inc_h;
    logic        nx_uf_h;

    // Stage-1 registers
    logic        s1_fp32;
    logic        s1_sign_h;
    logic        s1_sign_l;
    logic [22:0] s1_mant_l;
    logic [9:0]  s1_exp_l;
    logic        s1_inc_l;
    logic        s1_hid_l;
    logic        s1_uf_l;
    logic [9:0]  s1_mant_h;
    logic [6:0]  s1_exp_h;
    logic        s1_inc_h;
    logic        s1_hid_h;
    logic        s1_uf_h;
`ifdef FPALL_ROUND_FLAGS_EN
    logic        s1_inx_l;
    logic        s1_inx_h;
    logic [2:0]  flg_h;
    logic [2:0]  flg_l;
`endif

    // Stage-2 combinational
    logic [23:0] sum_l;
    logic [10:0] sum_h;
    logic        carry_l;
    logic [10:0] fexp_l;
    logic [7:0]  fexp_h;
    logic        zero_l;
    logic        zero_h;
    logic        ovf_l;
    logic        ovf_h;
    logic [31:0] pack_32;
    logic [15:0] pack_hi;
    logic [15:0] pack_lo;
    logic [31:0] pack_res;

    assign s2_free   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_free;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Stage 1: split lanes, subtract the LZC from the exponent, decide the round increment
    always_comb begin
        is_fp32   = (fmt == FP32);
        adj_32    = {1'b0, exp_l} - {5'b0, cnt_l};
        adj_h16   = {1'b0, exp_h} - {2'b0, cnt_h};
        adj_l16   = {1'b0, exp_l[5:0]} - {2'b0, cnt_l};

        nx_mant_l = is_fp32 ? frac_i[26:4] : {13'b0, frac_i[12:3]};
        nx_exp_l  = is_fp32 ? adj_32 : {{3{adj_l16[6]}}, adj_l16};
        nx_hid_l  = is_fp32 ? frac_i[27] : frac_i[13];
        nx_lsb_l  = is_fp32 ? frac_i[4] : frac_i[3];
        nx_grd_l  = is_fp32 ? frac_i[3] : frac_i[2];
        nx_stk_l  = is_fp32 ? (|frac_i[2:0]) : (|frac_i[1:0]);
        nx_inc_l  = nx_grd_l & (nx_stk_l | nx_lsb_l);
        nx_uf_l   = nx_exp_l[9] | (nx_exp_l == 10'd0);

        nx_mant_h = frac_i[26:17];
        nx_hid_h  = frac_i[27];
        nx_grd_h  = frac_i[16];
        nx_stk_h  = |frac_i[15:14];
        nx_inc_h  = nx_grd_h & (nx_stk_h | frac_i[17]);
        nx_uf_h   = adj_h16[6] | (adj_h16 == 7'd0);
    end

    // Stage-1 valid: cleared on reset, refilled whenever the stage may accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 payload: format and lane decisions travel together with the beat
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_fp32   <= is_fp32;
            s1_sign_h <= sign_h;
            s1_sign_l <= sign_l;
            s1_mant_l <= nx_mant_l;
            s1_exp_l  <= nx_exp_l;
            s1_inc_l  <= nx_inc_l;
            s1_hid_l  <= nx_hid_l;
            s1_uf_l   <= nx_uf_l;
            s1_mant_h <= nx_mant_h;
            s1_exp_h  <= adj_h16;
            s1_inc_h  <= nx_inc_h;
            s1_hid_h  <= nx_hid_h;
            s1_uf_h   <= nx_uf_h;
`ifdef FPALL_ROUND_FLAGS_EN
            s1_inx_l  <= nx_grd_l | nx_stk_l;
            s1_inx_h  <= nx_grd_h | nx_stk_h;
`endif
        end
    end

    // Stage 2: add the increment, fold mantissa carry into the exponent, saturate and pack
    always_comb begin
        sum_l   = {1'b0, s1_mant_l} + {23'b0, s1_inc_l};
        sum_h   = {1'b0, s1_mant_h} + {10'b0, s1_inc_h};
        carry_l = s1_fp32 ? sum_l[23] : sum_l[10];
        // one extra bit so the largest input exponent plus a carry cannot wrap negative
        fexp_l  = {s1_exp_l[9], s1_exp_l} + {10'b0, carry_l};
        fexp_h  = {s1_exp_h[6], s1_exp_h} + {7'b0, sum_h[10]};
        zero_l  = ~s1_hid_l | s1_uf_l;
        zero_h  = ~s1_hid_h | s1_uf_h;
        ovf_l   = s1_fp32 ? ($signed(fexp_l) >= 11'sd255) : ($signed(fexp_l) >= 11'sd31);
        ovf_h   = $signed(fexp_h) >= 8'sd31;

        if (zero_l) begin
            pack_32 = {s1_sign_l, 31'b0};
            pack_lo = {s1_sign_l, 15'b0};
        end else if (ovf_l) begin
            pack_32 = {s1_sign_l, 8'hFF, 23'b0};
            pack_lo = {s1_sign_l, 5'h1F, 10'b0};
        end else begin
            pack_32 = {s1_sign_l, fexp_l[7:0], sum_l[22:0]};
            pack_lo = {s1_sign_l, fexp_l[4:0], sum_l[9:0]};
        end

        if (zero_h) begin
            pack_hi = {s1_sign_h, 15'b0};
        end else if (ovf_h) begin
            pack_hi = {s1_sign_h, 5'h1F, 10'b0};
        end else begin
            pack_hi = {s1_sign_h, fexp_h[4:0], sum_h[9:0]};
        end

        pack_res = s1_fp32 ? pack_32 : {pack_hi, pack_lo};
`ifdef FPALL_ROUND_FLAGS_EN
        flg_l = {~zero_l & ovf_l, s1_hid_l & s1_uf_l, s1_inx_l};
        flg_h = s1_fp32 ? 3'b000 : {~zero_h & ovf_h, s1_hid_h & s1_uf_h, s1_inx_h};
`endif
    end

    // Stage-2 output register: holds result steady while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= 32'd0;
`ifdef FPALL_ROUND_FLAGS_EN
            flags_h  <= 3'b000;
            flags_l  <= 3'b000;
`endif
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
            end
            if (s2_free && s1_valid) begin
                result   <= pack_res;
`ifdef FPALL_ROUND_FLAGS_EN
                flags_h  <= flg_h;
                flags_l  <= flg_l;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// tb/tb_fp_round_pack.sv - self-checking bench for fp_round_pack (flag checks when FPALL_ROUND_FLAGS_EN)
module tb_fp_round_pack;
    import FPALL_pkg::*;

    typedef struct {
        fp_fmt_e     fmt;
        logic [27:0] frac;
        logic [4:0]  cnt_h;
        logic [4:0]  cnt_l;
        logic [5:0]  exp_h;
        logic [8:0]  exp_l;
        logic        sign_h;
        logic        sign_l;
        logic [31:0] res;
        logic [2:0]  fh;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fh;
        logic [2:0]  fl;
        bit          chkf;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    fp_fmt_e     fmt;
    logic [27:0] frac_i;
    logic [4:0]  cnt_h;
    logic [4:0]  cnt_l;
    logic [5:0]  exp_h;
    logic [8:0]  exp_l;
    logic        sign_h;
    logic        sign_l;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FPALL_ROUND_FLAGS_EN
    logic [2:0]  flags_h;
    logic [2:0]  flags_l;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        cur_exp;
    bit          rnd_bp  = 1'b0;
    bit          holding = 1'b0;
    logic [31:0] held;
    vec_t        tbl[$];

    fp_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .frac_i    (frac_i),
        .cnt_h     (cnt_h),
        .cnt_l     (cnt_l),
        .exp_h     (exp_h),
        .exp_l     (exp_l),
        .sign_h    (sign_h),
        .sign_l    (sign_l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FPALL_ROUND_FLAGS_EN
        ,
        .flags_h   (flags_h),
        .flags_l   (flags_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lane_model(input bit fp32, input logic [27:0] f,
                                                input int e, input int c, input logic s);
        int mb  = fp32 ? 23 : 10;
        int eb  = fp32 ? 8 : 5;
        int rb  = fp32 ? 4 : 3;
        int top = fp32 ? 27 : 13;
        int adj = e - c;
        logic [31:0] m;
        logic [31:0] emax;
        logic [31:0] sbit;
        bit g;
        bit st;
        m    = 32'(f >> rb) & ((32'd1 << mb) - 32'd1);
        g    = f[rb-1];
        st   = (f & ((28'd1 << (rb - 1)) - 28'd1)) != 28'd0;
        emax = (32'd1 << eb) - 32'd1;
        sbit = s ? (32'd1 << (eb + mb)) : 32'd0;
        if (!f[top] || adj <= 0) return sbit;
        if (g && (st || m[0])) m = m + 32'd1;
        if (m == (32'd1 << mb)) begin
            m = 32'd0;
            adj++;
        end
        if (32'(adj) >= emax) return sbit | (emax << mb);
        return sbit | (32'(adj) << mb) | m;
    endfunction

    function automatic logic [31:0] model(input vec_t v);
        logic [31:0] hi;
        logic [31:0] lo;
        if (v.fmt == FP32) return lane_model(1'b1, v.frac, int'(v.exp_l), int'(v.cnt_l), v.sign_l);
        hi = lane_model(1'b0, {14'b0, v.frac[27:14]}, int'(v.exp_h), int'(v.cnt_h), v.sign_h);
        lo = lane_model(1'b0, {14'b0, v.frac[13:0]}, int'({3'b0, v.exp_l[5:0]}), int'(v.cnt_l), v.sign_l);
        return {hi[15:0], lo[15:0]};
    endfunction

    function automatic exp_t to_exp(input vec_t v, input int id);
        exp_t e;
        e = '{v.res, v.fh, v.fl, 1'b1, id};
        return e;
    endfunction

    task automatic apply(input vec_t v, input exp_t e);
        fmt     = v.fmt;
        frac_i  = v.frac;
        cnt_h   = v.cnt_h;
        cnt_l   = v.cnt_l;
        exp_h   = v.exp_h;
        exp_l   = v.exp_l;
        sign_h  = v.sign_h;
        sign_l  = v.sign_l;
        cur_exp = e;
    endtask

    task automatic send(input vec_t v, input exp_t e);
        int n = 0;
        bit ok = 1'b0;
        apply(v, e);
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d required 0", sb.size());
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on delivered output, watch stalls
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            holding = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid) begin
                if (holding) check("hold_stable", result, held);
                if (out_ready) begin
                    holding = 1'b0;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h required none", result);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("result[%0d]", e.id), result, e.res);
`ifdef FPALL_ROUND_FLAGS_EN
                        if (e.chkf) begin
                            check($sformatf("flags_h[%0d]", e.id), {29'b0, flags_h}, {29'b0, e.fh});
                            check($sformatf("flags_l[%0d]", e.id), {29'b0, flags_l}, {29'b0, e.fl});
                        end
`endif
                    end
                end else begin
                    holding = 1'b1;
                    held    = result;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int   acc;
        int   ghost;
        bit   fired;
        int   bp_idx[3];
        vec_t v;
        exp_t e;

        //          fmt   frac          cnt_h cnt_l exp_h exp_l     sh    sl    result        fh      fl
        tbl.push_back('{FP32, 28'h8000010, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h3F800001, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h8000008, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h3F800000, 3'b000, 3'b001});
        tbl.push_back('{FP32, 28'h8000018, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h3F800002, 3'b000, 3'b001});
        tbl.push_back('{FP32, 28'hFFFFFF8, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h40000000, 3'b000, 3'b001});
        tbl.push_back('{FP32, 28'hFFFFFF8, 5'd0, 5'd0, 6'd0,  9'd254, 1'b0, 1'b0, 32'h7F800000, 3'b000, 3'b101});
        tbl.push_back('{FP32, 28'hFFFFFF8, 5'd0, 5'd5, 6'd0,  9'd3,   1'b0, 1'b0, 32'h00000000, 3'b000, 3'b011});
        tbl.push_back('{FP32, 28'h8000010, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b1, 32'hBF800001, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h8000000, 5'd7, 5'd3, 6'd9,  9'd130, 1'b1, 1'b0, 32'h3F800000, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h0000000, 5'd0, 5'd0, 6'd0,  9'd100, 1'b0, 1'b1, 32'h80000000, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h8000000, 5'd0, 5'd5, 6'd0,  9'd5,   1'b0, 1'b0, 32'h00000000, 3'b000, 3'b010});
        tbl.push_back('{FP32, 28'h8000000, 5'd0, 5'd5, 6'd0,  9'd6,   1'b0, 1'b0, 32'h00800000, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h8000000, 5'd0, 5'd0, 6'd0,  9'd255, 1'b0, 1'b0, 32'h7F800000, 3'b000, 3'b100});
        tbl.push_back('{FP32, 28'h8000000, 5'd0, 5'd0, 6'd0,  9'd254, 1'b0, 1'b0, 32'h7F000000, 3'b000, 3'b000});
        tbl.push_back('{FP32, 28'h8000009, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h3F800001, 3'b000, 3'b001});
        tbl.push_back('{FP32, 28'h8000007, 5'd0, 5'd0, 6'd0,  9'd127, 1'b0, 1'b0, 32'h3F800000, 3'b000, 3'b001});
        tbl.push_back('{FP16, 28'h8020000, 5'd0, 5'd0, 6'd15, 9'd0,   1'b0, 1'b0, 32'h3C010000, 3'b000, 3'b000});
        tbl.push_back('{FP16, 28'h0002008, 5'd0, 5'd0, 6'd0,  9'd15,  1'b1, 1'b1, 32'h8000BC01, 3'b000, 3'b000});
        tbl.push_back('{FP16, 28'h8003FFC, 5'd0, 5'd0, 6'd15, 9'd15,  1'b0, 1'b0, 32'h3C004000, 3'b000, 3'b001});
        tbl.push_back('{FP16, 28'hFFF2000, 5'd0, 5'd0, 6'd30, 9'd15,  1'b0, 1'b0, 32'h7C003C00, 3'b101, 3'b000});
        tbl.push_back('{FP16, 28'h8002000, 5'd2, 5'd2, 6'd2,  9'h1C3, 1'b0, 1'b0, 32'h00000400, 3'b010, 3'b000});
        tbl.push_back('{FP16, 28'h8002000, 5'd0, 5'd0, 6'd31, 9'd30,  1'b0, 1'b0, 32'h7C007800, 3'b100, 3'b000});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply(tbl[0], to_exp(tbl[0], 0));
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Two-cycle latency on an empty pipe
        send(tbl[0], to_exp(tbl[0], 0));
        check("latency_early", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        check("latency_result", result, 32'h3F800001);
        drain();

        // Table vectors, back to back
        foreach (tbl[i]) send(tbl[i], to_exp(tbl[i], i));
        drain();

        // Random vectors against the model with random downstream stalls
        rnd_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            v.fmt    = ($urandom_range(0, 1) != 0) ? FP32 : FP16;
            v.frac   = 28'($urandom);
            if (v.fmt == FP32 && $urandom_range(0, 7) != 0) v.frac[27] = 1'b1;
            v.cnt_h  = 5'($urandom_range(0, 3));
            v.cnt_l  = 5'($urandom_range(0, 3));
            v.exp_h  = 6'($urandom_range(0, 34));
            v.exp_l  = (v.fmt == FP32) ? 9'($urandom_range(0, 300)) : 9'($urandom);
            v.sign_h = 1'($urandom);
            v.sign_l = 1'($urandom);
            e = '{model(v), 3'b000, 3'b000, 1'b0, 1000 + i};
            send(v, e);
        end
        rnd_bp = 1'b0;
        drain();

        // Backpressure: 4 stalled cycles with 3 beats offered
        bp_idx[0] = 1;
        bp_idx[1] = 2;
        bp_idx[2] = 3;
        out_ready = 1'b0;
        acc = 0;
        apply(tbl[bp_idx[0]], to_exp(tbl[bp_idx[0]], 100));
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            fired = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (fired) begin
                acc++;
                if (acc < 3) apply(tbl[bp_idx[acc]], to_exp(tbl[bp_idx[acc]], 100 + acc));
                else in_valid = 1'b0;
            end
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        send(tbl[bp_idx[2]], to_exp(tbl[bp_idx[2]], 102));
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(tbl[4], to_exp(tbl[4], 200));
        send(tbl[5], to_exp(tbl[5], 201));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        ghost = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check("rst_no_ghost", 32'(ghost), 32'd0);

        // Pipe still works after the mid-flight reset
        send(tbl[3], to_exp(tbl[3], 300));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
